// File: rtl/pc_ctrl_unit.sv
// Fetch-stage program counter: sequential advance, trap vectoring, EX redirect
// with capture during stalls, and a circular return-address stack for call/ret.
module pc_ctrl_unit #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('h0100),
  parameter int              STEP      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            call_valid,
  input  logic [PC_W-1:0] call_target,
  input  logic            ret_valid,
  output logic [PC_W-1:0] current_pc,
  output logic            redirect_pending,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_miss
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pend_pc;
  logic [PC_W-1:0]  pc_seq;
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] ras_cnt;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  // ras_ptr points at the next free slot, so the top of stack sits one below it.
  assign pc_seq  = current_pc + PC_W'(STEP);
  assign ptr_inc = ras_ptr + PTR_W'(1);
  assign ptr_dec = ras_ptr - PTR_W'(1);

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == DEPTH_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_pc       <= RESET_PC;
      redirect_pending <= 1'b0;
      pend_pc          <= '0;
      ras_ptr          <= '0;
      ras_cnt          <= '0;
      ras_miss         <= 1'b0;
      // NOTE: the stack is a handful of flops, so clearing every entry on reset is cheap and keeps its contents deterministic.
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees the pre-edge values.
      ras_miss <= 1'b0;
      if (trap_valid) begin
        current_pc       <= TRAP_VEC;
        redirect_pending <= 1'b0;
        ras_ptr          <= '0;
        ras_cnt          <= '0;
      end else if (redirect_valid && !stall) begin
        current_pc       <= redirect_pc;
        redirect_pending <= 1'b0;
      end else if (redirect_valid) begin
        redirect_pending <= 1'b1;
        pend_pc          <= redirect_pc;
      end else if (stall) begin
        current_pc <= current_pc;
      end else if (redirect_pending) begin
        current_pc       <= pend_pc;
        redirect_pending <= 1'b0;
      end else if (ret_valid) begin
        if (ras_empty) begin
          current_pc <= pc_seq;
          ras_miss   <= 1'b1;
        end else begin
          current_pc <= ras_mem[ptr_dec];
          ras_ptr    <= ptr_dec;
          ras_cnt    <= ras_cnt - CNT_W'(1);
        end
      end else if (call_valid) begin
        // A push onto a full stack lands on the oldest entry; the count saturates.
        ras_mem[ras_ptr] <= pc_seq;
        ras_ptr          <= ptr_inc;
        if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
        current_pc <= call_target;
      end else begin
        current_pc <= pc_seq;
      end
    end
  end

endmodule
